// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, forward paths, EX handshake and registered EX outputs of the ID/EX stage; master drives the stage, slave is the stage
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W = 32
);
    logic              id_valid_i;
    logic [XLEN-1:0]   id_pc_i;
    logic [31:0]       id_inst_i;
    logic [REG_AW-1:0] id_rs1_addr_i;
    logic [REG_AW-1:0] id_rs2_addr_i;
    logic              id_rs1_used_i;
    logic              id_rs2_used_i;
    logic [XLEN-1:0]   id_rs1_data_i;
    logic [XLEN-1:0]   id_rs2_data_i;
    logic [XLEN-1:0]   id_imm_i;
    logic [REG_AW-1:0] id_rd_addr_i;
    logic              id_wb_en_i;
    logic              id_is_load_i;
    logic              ex_fwd_en_i;
    logic [REG_AW-1:0] ex_fwd_rd_i;
    logic [XLEN-1:0]   ex_fwd_data_i;
    logic              mem_fwd_en_i;
    logic [REG_AW-1:0] mem_fwd_rd_i;
    logic [XLEN-1:0]   mem_fwd_data_i;
    logic              ex_ready_i;
    logic              flush_i;
    logic              stall_o;
    logic              ex_valid_o;
    logic [XLEN-1:0]   ex_pc_o;
    logic [31:0]       ex_inst_o;
    logic [XLEN-1:0]   ex_rs1_data_o;
    logic [XLEN-1:0]   ex_rs2_data_o;
    logic [XLEN-1:0]   ex_imm_o;
    logic [REG_AW-1:0] ex_rd_addr_o;
    logic              ex_wb_en_o;
    logic              ex_is_load_o;
    logic [CNT_W-1:0]  bubble_cnt_o;
    modport master (
        output id_valid_i, id_pc_i, id_inst_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_rd_addr_i, id_wb_en_i, id_is_load_i,
               ex_fwd_en_i, ex_fwd_rd_i, ex_fwd_data_i, mem_fwd_en_i, mem_fwd_rd_i, mem_fwd_data_i,
               ex_ready_i, flush_i,
        input  stall_o, ex_valid_o, ex_pc_o, ex_inst_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rd_addr_o, ex_wb_en_o, ex_is_load_o, bubble_cnt_o
    );
    modport slave (
        input  id_valid_i, id_pc_i, id_inst_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_rd_addr_i, id_wb_en_i, id_is_load_i,
               ex_fwd_en_i, ex_fwd_rd_i, ex_fwd_data_i, mem_fwd_en_i, mem_fwd_rd_i, mem_fwd_data_i,
               ex_ready_i, flush_i,
        output stall_o, ex_valid_o, ex_pc_o, ex_inst_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rd_addr_o, ex_wb_en_o, ex_is_load_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with capture-time forwarding, load-use bubble, back-pressure hold, flush and saturating bubble count (ports: clk, rest, bus slave)
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W = 32
) (
    input logic          clk,
    input logic          rest,
    id_ex_stage_if.slave bus
);
    typedef enum logic {RUN, BUBBLE} state_t;
    state_t state;
    logic hazard;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    always_comb begin
        hazard = state == RUN && bus.ex_valid_o && bus.ex_is_load_o && bus.ex_rd_addr_o != '0 && bus.id_valid_i &&
                 ((bus.id_rs1_used_i && bus.id_rs1_addr_i == bus.ex_rd_addr_o) ||
                  (bus.id_rs2_used_i && bus.id_rs2_addr_i == bus.ex_rd_addr_o));
        bus.stall_o = !rest && !bus.flush_i && (hazard || (!bus.ex_ready_i && bus.id_valid_i));
        rs1_fwd = bus.id_rs1_addr_i == '0 ? '0 :
                  bus.ex_fwd_en_i && bus.ex_fwd_rd_i == bus.id_rs1_addr_i ? bus.ex_fwd_data_i :
                  bus.mem_fwd_en_i && bus.mem_fwd_rd_i == bus.id_rs1_addr_i ? bus.mem_fwd_data_i : bus.id_rs1_data_i;
        rs2_fwd = bus.id_rs2_addr_i == '0 ? '0 :
                  bus.ex_fwd_en_i && bus.ex_fwd_rd_i == bus.id_rs2_addr_i ? bus.ex_fwd_data_i :
                  bus.mem_fwd_en_i && bus.mem_fwd_rd_i == bus.id_rs2_addr_i ? bus.mem_fwd_data_i : bus.id_rs2_data_i;
    end
    always_ff @(posedge clk) begin
        if (rest) begin
            state             <= RUN;
            bus.ex_valid_o    <= 1'b0;
            bus.ex_pc_o       <= '0;
            bus.ex_inst_o     <= '0;
            bus.ex_rs1_data_o <= '0;
            bus.ex_rs2_data_o <= '0;
            bus.ex_imm_o      <= '0;
            bus.ex_rd_addr_o  <= '0;
            bus.ex_wb_en_o    <= 1'b0;
            bus.ex_is_load_o  <= 1'b0;
            bus.bubble_cnt_o  <= '0;
        end else if (bus.flush_i) begin
            state            <= RUN;
            bus.ex_valid_o   <= 1'b0;
            bus.ex_wb_en_o   <= 1'b0;
            bus.ex_is_load_o <= 1'b0;
        end else if (bus.ex_ready_i) begin
            if (hazard) begin
                state            <= BUBBLE;
                bus.ex_valid_o   <= 1'b0;
                bus.ex_wb_en_o   <= 1'b0;
                bus.ex_is_load_o <= 1'b0;
                bus.bubble_cnt_o <= &bus.bubble_cnt_o ? bus.bubble_cnt_o : bus.bubble_cnt_o + CNT_W'(1);
            end else begin
                state             <= RUN;
                bus.ex_valid_o    <= bus.id_valid_i;
                bus.ex_pc_o       <= bus.id_pc_i;
                bus.ex_inst_o     <= bus.id_inst_i;
                bus.ex_rs1_data_o <= rs1_fwd;
                bus.ex_rs2_data_o <= rs2_fwd;
                bus.ex_imm_o      <= bus.id_imm_i;
                bus.ex_rd_addr_o  <= bus.id_rd_addr_i;
                bus.ex_wb_en_o    <= bus.id_valid_i && bus.id_wb_en_i;
                bus.ex_is_load_o  <= bus.id_valid_i && bus.id_is_load_i;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with hand-computed expectations for id_ex_stage (3-bit bubble counter)
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rest;
    int n_chk = 0;
    int n_fail = 0;
    id_ex_stage_if #(.CNT_W(3)) bus ();
    id_ex_stage #(.CNT_W(3)) dut (.clk(clk), .rest(rest), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.id_valid_i = 0; bus.id_pc_i = 0; bus.id_inst_i = 0;
        bus.id_rs1_addr_i = 0; bus.id_rs2_addr_i = 0; bus.id_rs1_used_i = 0; bus.id_rs2_used_i = 0;
        bus.id_rs1_data_i = 0; bus.id_rs2_data_i = 0; bus.id_imm_i = 0; bus.id_rd_addr_i = 0;
        bus.id_wb_en_i = 0; bus.id_is_load_i = 0;
        bus.ex_fwd_en_i = 0; bus.ex_fwd_rd_i = 0; bus.ex_fwd_data_i = 0;
        bus.mem_fwd_en_i = 0; bus.mem_fwd_rd_i = 0; bus.mem_fwd_data_i = 0;
        bus.ex_ready_i = 1; bus.flush_i = 0;
    endtask
    task automatic issue(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd, input logic ld);
        bus.id_valid_i = 1; bus.id_pc_i = pc; bus.id_inst_i = 32'h13 | pc; bus.id_imm_i = pc + 4;
        bus.id_rs1_addr_i = r1; bus.id_rs1_data_i = d1; bus.id_rs1_used_i = 1;
        bus.id_rs2_addr_i = r2; bus.id_rs2_data_i = d2; bus.id_rs2_used_i = 1;
        bus.id_rd_addr_i = rd; bus.id_wb_en_i = 1; bus.id_is_load_i = ld;
    endtask
    initial begin
        idle();
        rest = 1;
        bus.ex_ready_i = 0;
        bus.id_valid_i = 1; bus.id_pc_i = $urandom; bus.id_inst_i = $urandom; bus.id_imm_i = $urandom;
        bus.id_rs1_addr_i = 5'($urandom); bus.id_rs1_data_i = $urandom; bus.id_rd_addr_i = 5'($urandom);
        bus.id_wb_en_i = 1; bus.id_is_load_i = 1;
        #1 check("rst_stall", 32'(bus.stall_o), 0);
        step();
        step();
        check("rst_valid", 32'(bus.ex_valid_o), 0);
        check("rst_pc", bus.ex_pc_o, 0);
        check("rst_rs1", bus.ex_rs1_data_o, 0);
        check("rst_wb", 32'(bus.ex_wb_en_o), 0);
        check("rst_load", 32'(bus.ex_is_load_o), 0);
        check("rst_cnt", 32'(bus.bubble_cnt_o), 0);
        check("rst_stall2", 32'(bus.stall_o), 0);
        rest = 0;
        idle();
        issue(32'h100, 1, 32'hAAAA, 2, 32'h5555, 0, 0);
        bus.id_inst_i = 32'h00208033;
        #1 check("pass_stall", 32'(bus.stall_o), 0);
        step();
        check("pass_pc", bus.ex_pc_o, 32'h100);
        check("pass_inst", bus.ex_inst_o, 32'h00208033);
        check("pass_rs1", bus.ex_rs1_data_o, 32'hAAAA);
        check("pass_rs2", bus.ex_rs2_data_o, 32'h5555);
        check("pass_imm", bus.ex_imm_o, 32'h104);
        check("pass_valid", 32'(bus.ex_valid_o), 1);
        check("pass_wb", 32'(bus.ex_wb_en_o), 1);
        issue(32'h110, 5, 32'h1, 2, 32'h5555, 6, 0);
        bus.ex_fwd_en_i = 1; bus.ex_fwd_rd_i = 5; bus.ex_fwd_data_i = 32'h22;
        bus.mem_fwd_en_i = 1; bus.mem_fwd_rd_i = 5; bus.mem_fwd_data_i = 32'h33;
        step();
        check("fwd_ex", bus.ex_rs1_data_o, 32'h22);
        check("fwd_rf_rs2", bus.ex_rs2_data_o, 32'h5555);
        check("fwd_rd", 32'(bus.ex_rd_addr_o), 6);
        bus.ex_fwd_en_i = 0;
        step();
        check("fwd_mem", bus.ex_rs1_data_o, 32'h33);
        bus.ex_fwd_en_i = 1; bus.ex_fwd_rd_i = 0; bus.mem_fwd_rd_i = 0; bus.id_rs1_addr_i = 0;
        step();
        check("fwd_x0", bus.ex_rs1_data_o, 0);
        idle();
        bus.id_valid_i = 0; bus.id_wb_en_i = 1; bus.id_is_load_i = 1;
        step();
        check("inv_valid", 32'(bus.ex_valid_o), 0);
        check("inv_wb", 32'(bus.ex_wb_en_o), 0);
        check("inv_load", 32'(bus.ex_is_load_o), 0);
        issue(32'h200, 1, 32'h7, 0, 0, 3, 1);
        step();
        check("lu_load_in_ex", 32'(bus.ex_is_load_o), 1);
        issue(32'h204, 3, 32'h0, 1, 32'h11, 4, 0);
        #1 check("lu_stall", 32'(bus.stall_o), 1);
        step();
        check("lu_bubble_valid", 32'(bus.ex_valid_o), 0);
        check("lu_bubble_wb", 32'(bus.ex_wb_en_o), 0);
        check("lu_cnt", 32'(bus.bubble_cnt_o), 1);
        check("lu_stall_end", 32'(bus.stall_o), 0);
        bus.mem_fwd_en_i = 1; bus.mem_fwd_rd_i = 3; bus.mem_fwd_data_i = 32'hBEEF;
        step();
        check("lu_cap_valid", 32'(bus.ex_valid_o), 1);
        check("lu_cap_pc", bus.ex_pc_o, 32'h204);
        check("lu_cap_rs1", bus.ex_rs1_data_o, 32'hBEEF);
        check("lu_cap_rs2", bus.ex_rs2_data_o, 32'h11);
        check("lu_cnt_hold", 32'(bus.bubble_cnt_o), 1);
        idle();
        issue(32'h208, 1, 32'h7, 0, 0, 0, 1);
        step();
        issue(32'h20C, 0, 32'h9, 0, 32'h9, 5, 0);
        #1 check("x0_stall", 32'(bus.stall_o), 0);
        step();
        check("x0_valid", 32'(bus.ex_valid_o), 1);
        check("x0_pc", bus.ex_pc_o, 32'h20C);
        check("x0_cnt", 32'(bus.bubble_cnt_o), 1);
        issue(32'h300, 1, 32'h1, 2, 32'h2, 7, 0);
        bus.ex_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_stall", 32'(bus.stall_o), 1);
            step();
            check("bp_pc", bus.ex_pc_o, 32'h20C);
            check("bp_valid", 32'(bus.ex_valid_o), 1);
            check("bp_rd", 32'(bus.ex_rd_addr_o), 5);
        end
        bus.flush_i = 1;
        #1 check("fl_stall", 32'(bus.stall_o), 0);
        step();
        check("fl_valid", 32'(bus.ex_valid_o), 0);
        check("fl_wb", 32'(bus.ex_wb_en_o), 0);
        idle();
        issue(32'h400, 1, 32'h1, 0, 0, 3, 1);
        step();
        issue(32'h404, 3, 32'h0, 0, 0, 4, 0);
        step();
        check("mid_bubble_cnt", 32'(bus.bubble_cnt_o), 2);
        rest = 1;
        step();
        rest = 0;
        check("mid_rst_cnt", 32'(bus.bubble_cnt_o), 0);
        check("mid_rst_valid", 32'(bus.ex_valid_o), 0);
        step();
        check("mid_cap_valid", 32'(bus.ex_valid_o), 1);
        check("mid_cap_pc", bus.ex_pc_o, 32'h404);
        for (int i = 0; i < 9; i++) begin
            issue(32'h500 + 32'(i * 8), 1, 32'h1, 0, 0, 3, 1);
            step();
            issue(32'h504 + 32'(i * 8), 3, 32'h0, 0, 0, 4, 0);
            step();
            check("sat_cnt", 32'(bus.bubble_cnt_o), i < 7 ? 32'(i + 1) : 7);
            step();
        end
        check("sat_final", 32'(bus.bubble_cnt_o), 7);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the ID stage and the EX stage of the RV32I core.
- Captures decoded fields and the operand values read from the register file. Applies EX/MEM forwarding at capture time.
- Detects load-use hazards, inserts a one-cycle bubble and stalls IF/ID. Honours EX back-pressure and branch flush.
- Keeps a saturating count of hazard-bubble cycles.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.
- CNT_W, 32, bubble-counter width.

Ports:
- clk  in  1  core clock
- rest  in  1  synchronous reset, active-high
- id_valid_i  in  1  ID presents a valid instruction
- id_pc_i  in  XLEN  instruction PC
- id_inst_i  in  32  raw instruction
- id_rs1_addr_i  in  REG_AW  rs1 index
- id_rs2_addr_i  in  REG_AW  rs2 index
- id_rs1_used_i  in  1  instruction reads rs1
- id_rs2_used_i  in  1  instruction reads rs2
- id_rs1_data_i  in  XLEN  rs1 value from regfile
- id_rs2_data_i  in  XLEN  rs2 value from regfile
- id_imm_i  in  XLEN  decoded immediate
- id_rd_addr_i  in  REG_AW  destination index
- id_wb_en_i  in  1  instruction writes rd
- id_is_load_i  in  1  instruction is a load
- ex_fwd_en_i, ex_fwd_rd_i, ex_fwd_data_i  in  1/REG_AW/XLEN  EX-stage result being produced
- mem_fwd_en_i, mem_fwd_rd_i, mem_fwd_data_i  in  1/REG_AW/XLEN  MEM-stage result
- ex_ready_i  in  1  EX accepts a new instruction this cycle
- flush_i  in  1  branch/jump taken; kill the ID→EX transfer
- stall_o  out  1  hold IF and ID this cycle (combinational)
- ex_valid_o, ex_pc_o, ex_inst_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rd_addr_o, ex_wb_en_o, ex_is_load_o  out  registered copies to EX
- bubble_cnt_o  out  CNT_W  load-use bubbles inserted

Behaviour:
- Reset: synchronous, active-high on rest.
  - At a clock edge with rest=1, all ex_* outputs and bubble_cnt_o become 0, and the FSM goes to RUN.
  - stall_o=0 while rest=1.
- Priority at each edge: rest > flush_i > !ex_ready_i (hold) > hazard (bubble) > capture.
- Load-use hazard (combinational), true when all of the following hold:
  - ex_valid_o=1, ex_is_load_o=1 and ex_rd_addr_o≠0;
  - id_valid_i=1;
  - either (id_rs1_used_i and id_rs1_addr_i=ex_rd_addr_o) or (id_rs2_used_i and id_rs2_addr_i=ex_rd_addr_o).
- stall_o = hazard | (!ex_ready_i & id_valid_i), forced to 0 when flush_i=1 or rest=1.
- FSM states:
  - RUN → BUBBLE when hazard is true and ex_ready_i=1.
    - At that edge: ex_valid_o←0, ex_wb_en_o←0, ex_is_load_o←0; the other fields are don't-care but held.
    - bubble_cnt_o increments and saturates at all-ones.
  - BUBBLE → RUN at the next edge. The held ID instruction is captured at that edge, with its operand taken from the mem forward path.
  - Flush in either state forces RUN.
- Capture (RUN, no hazard, ex_ready_i=1):
  - Latency is 1 cycle: the ID fields appear on ex_* at the next edge.
  - ex_valid_o←id_valid_i.
  - When id_valid_i=0, ex_wb_en_o and ex_is_load_o are 0.
- Operand forwarding at capture, evaluated per operand, first match wins:
  1. address 0 → 0 (ignores both the regfile and the forward paths);
  2. ex_fwd_en_i and ex_fwd_rd_i equals the address → ex_fwd_data_i;
  3. mem_fwd_en_i and mem_fwd_rd_i equals the address → mem_fwd_data_i;
  4. otherwise the regfile data.
- Hold (ex_ready_i=0, no flush): all ex_* outputs and the FSM state keep their values. No bubble is counted.
- Flush: at the edge, ex_valid_o, ex_wb_en_o and ex_is_load_o ←0; the FSM goes to RUN. Flush overrides hold.
- Reset mid-bubble: the FSM returns to RUN, and the counter clears to 0.

Test Plan:
- Reset: rest=1 for 2 cycles, with id_valid_i=1 and random fields → all ex_* =0, stall_o=0, bubble_cnt_o=0.
- Passthrough: pc=0x100, inst=0x00208033, rs1=1 with data 0xAAAA, rs2=2 with data 0x5555, no forwarding → the next cycle shows ex_pc_o=0x100, ex_rs1_data_o=0xAAAA, ex_rs2_data_o=0x5555, ex_valid_o=1.
- Forward priority:
  - rs1=5, regfile data 0x1, ex_fwd (5, 0x22) and mem_fwd (5, 0x33) → ex_rs1_data_o=0x22.
  - With ex_fwd_en_i=0 → 0x33.
  - With rs1=0 and ex_fwd_rd_i=0 → 0.
- Load-use:
  - A load with rd=3 is in EX and ID issues "add x4,x3,x1" → stall_o=1 for exactly 1 cycle, ex_valid_o=0 for 1 cycle, bubble_cnt_o goes 0→1.
  - The following cycle, with mem_fwd (3, 0xBEEF) → ex_rs1_data_o=0xBEEF.
  - A load to x0 followed by a use of x0 → no stall.
- Back-pressure and flush:
  - ex_ready_i=0 for 3 cycles → ex_* are stable and stall_o=1.
  - Assert flush_i together with ex_ready_i=0 → the next edge gives ex_valid_o=0 and stall_o=0 during the flush cycle.
- Saturation: with CNT_W=3, force 9 hazards → bubble_cnt_o=7.
